// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the EX-stage multi-cycle divider: widths, FSM
// encodings, handshake symbols and a small arithmetic helper.
package div_ctrl_pkg;

  localparam int DATA_W    = 32;
  localparam int DIV_CNT_W = 6;

  // Number of shift-subtract iterations; the finalize cycle follows the last one.
  localparam logic [DIV_CNT_W-1:0] DIV_STEPS = 6'd32;

  typedef enum logic [1:0] {
    DIV_IDLE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  // Two's-complement negate (modulo 2^DATA_W) when neg is set, else pass through.
  function automatic logic [DATA_W-1:0] cond_negate(input logic [DATA_W-1:0] v,
                                                    input logic neg);
    logic [DATA_W-1:0] r;
    if (neg) begin
      r = ~v + {{(DATA_W-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Request/response bundle between the EX stage (master) and the divider (slave).
interface div_ctrl_if;
  import div_ctrl_pkg::*;

  logic                  div_start_i;
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic                  stall_req_o;

  modport master (
    output div_start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
    input  result_o, ready_o, stall_req_o
  );

  modport slave (
    input  div_start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
    output result_o, ready_o, stall_req_o
  );

endinterface

// File: rtl/div_ctrl_step.sv
// One radix-2 restoring iteration. The partial register holds the running
// remainder in its upper bits and the dividend/quotient bits below; the
// 33-bit window [2W:W] is compared against the divisor each step.
module div_ctrl_step
  import div_ctrl_pkg::*;
(
  input  logic [2*DATA_W:0]   partial_i,
  input  logic [DATA_W-1:0]   divisor_i,
  output logic [2*DATA_W-1:0] partial_o,   // next partial bits [2W:1]
  output logic                quot_bit_o   // next partial bit 0
);

  logic              keep_s;
  logic [DATA_W-1:0] trial_s;

  // Trial subtraction: when the window is >= divisor the difference fits in
  // DATA_W bits, so only the low half of the trial is ever kept.
  always_comb begin
    keep_s  = (partial_i[2*DATA_W:DATA_W] >= {1'b0, divisor_i});
    trial_s = partial_i[2*DATA_W-1:DATA_W] - divisor_i;
    if (keep_s) begin
      partial_o  = {trial_s, partial_i[DATA_W-1:0]};
      quot_bit_o = 1'b1;
    end else begin
      partial_o  = partial_i[2*DATA_W-1:0];
      quot_bit_o = 1'b0;
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle 32-bit DIV/DIVU controller: sequences 32 restoring steps,
// fixes up signs, stalls the pipeline while busy and supports annulment.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input logic       clk,
  input logic       rst,
  div_ctrl_if.slave bus
);

  div_state_e           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [2*DATA_W:0]    partial_q, partial_d;
  logic [DATA_W-1:0]    divisor_q, divisor_d;
  logic                 sign_en_q, sign_en_d;
  logic                 neg_dvd_q, neg_dvd_d;
  logic                 neg_dvs_q, neg_dvs_d;
  logic [2*DATA_W-1:0]  result_q, result_d;
  logic                 ready_q, ready_d;

  logic [2*DATA_W-1:0]  step_partial_s;
  logic                 step_qbit_s;
  logic                 go_s;
  logic                 in_neg_dvd_s;
  logic                 in_neg_dvs_s;
  logic [DATA_W-1:0]    quot_s;
  logic [DATA_W-1:0]    rem_s;

  div_ctrl_step u_step (
    .partial_i  (partial_q),
    .divisor_i  (divisor_q),
    .partial_o  (step_partial_s),
    .quot_bit_o (step_qbit_s)
  );

  // Next-state, datapath loads and output register values.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    partial_d    = partial_q;
    divisor_d    = divisor_q;
    sign_en_d    = sign_en_q;
    neg_dvd_d    = neg_dvd_q;
    neg_dvs_d    = neg_dvs_q;
    result_d     = result_q;
    ready_d      = ready_q;
    go_s         = (bus.div_start_i == DivStart) && !bus.annul_i;
    in_neg_dvd_s = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
    in_neg_dvs_s = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
    quot_s       = cond_negate(partial_q[DATA_W-1:0], sign_en_q & (neg_dvd_q ^ neg_dvs_q));
    rem_s        = cond_negate(partial_q[2*DATA_W:DATA_W+1], sign_en_q & neg_dvd_q);
    case (state_q)
      DIV_IDLE: begin
        if (go_s && (bus.opdata2_i == {DATA_W{1'b0}})) begin
          state_d = DIV_BY_ZERO;
        end else if (go_s) begin
          state_d   = DIV_ON;
          sign_en_d = bus.signed_div_i;
          neg_dvd_d = in_neg_dvd_s;
          neg_dvs_d = in_neg_dvs_s;
          // Upper remainder half cleared; dividend magnitude sits one bit up
          // so the first window sees its MSB.
          partial_d = {{DATA_W{1'b0}}, cond_negate(bus.opdata1_i, in_neg_dvd_s), 1'b0};
          divisor_d = cond_negate(bus.opdata2_i, in_neg_dvs_s);
          cnt_d     = {DIV_CNT_W{1'b0}};
        end else begin
          state_d = DIV_IDLE;
        end
      end
      DIV_BY_ZERO: begin
        if (bus.annul_i) begin
          state_d = DIV_IDLE;
        end else begin
          state_d  = DIV_END;
          result_d = {(2*DATA_W){1'b0}};
          ready_d  = DivResultReady;
        end
      end
      DIV_ON: begin
        if (bus.annul_i) begin
          state_d = DIV_IDLE;
          cnt_d   = {DIV_CNT_W{1'b0}};
        end else if (cnt_q != DIV_STEPS) begin
          partial_d = {step_partial_s, step_qbit_s};
          cnt_d     = cnt_q + 6'd1;
        end else begin
          state_d  = DIV_END;
          result_d = {rem_s, quot_s};
          ready_d  = DivResultReady;
        end
      end
      DIV_END: begin
        if ((bus.div_start_i == DivStop) || bus.annul_i) begin
          state_d  = DIV_IDLE;
          result_d = {(2*DATA_W){1'b0}};
          ready_d  = DivResultNotReady;
        end else begin
          state_d = DIV_END;
        end
      end
      default: begin
        state_d  = DIV_IDLE;
        result_d = {(2*DATA_W){1'b0}};
        ready_d  = DivResultNotReady;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= {DIV_CNT_W{1'b0}};
      partial_q <= {(2*DATA_W+1){1'b0}};
      divisor_q <= {DATA_W{1'b0}};
      sign_en_q <= 1'b0;
      neg_dvd_q <= 1'b0;
      neg_dvs_q <= 1'b0;
      result_q  <= {(2*DATA_W){1'b0}};
      ready_q   <= DivResultNotReady;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      partial_q <= partial_d;
      divisor_q <= divisor_d;
      sign_en_q <= sign_en_d;
      neg_dvd_q <= neg_dvd_d;
      neg_dvs_q <= neg_dvs_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.result_o    = result_q;
  assign bus.ready_o     = ready_q;
  assign bus.stall_req_o = (bus.div_start_i == DivStart) && !bus.annul_i && (state_q != DIV_END);

endmodule

// File: tb/tb_div_ctrl.sv
// Randomized bench for div_ctrl: a transaction-level reference model
// (plain integer division plus a latency countdown) is compared against the
// DUT on every cycle, alongside directed cases with literal expectations.
module tb_div_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_ctrl_if dif();

  div_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  int total = 0;
  int bad   = 0;

  typedef enum int {M_IDLE, M_BUSY, M_DONE} mphase_t;
  mphase_t     m_phase = M_IDLE;
  int          m_left  = 0;
  logic [63:0] m_res   = 64'd0;

  // Architectural result: {remainder, quotient}; divide by zero yields zero.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  // Reference model: a request occupies 33 busy cycles (1 for divide by zero),
  // then the result is shown until start drops or annul arrives.
  always @(posedge clk) begin
    if (rst) begin
      m_phase = M_IDLE;
      m_left  = 0;
      m_res   = 64'd0;
    end else begin
      case (m_phase)
        M_IDLE: if (dif.div_start_i && !dif.annul_i) begin
          m_phase = M_BUSY;
          m_left  = (dif.opdata2_i == 32'd0) ? 1 : 33;
          m_res   = ref_div(dif.opdata1_i, dif.opdata2_i, dif.signed_div_i);
        end
        M_BUSY: if (dif.annul_i) begin
          m_phase = M_IDLE;
        end else begin
          m_left--;
          if (m_left == 0) m_phase = M_DONE;
        end
        M_DONE: if (!dif.div_start_i || dif.annul_i) m_phase = M_IDLE;
        default: m_phase = M_IDLE;
      endcase
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic        e_ready;
    logic [63:0] e_res;
    logic        e_stall;
    e_ready = (m_phase == M_DONE);
    e_res   = e_ready ? m_res : 64'd0;
    e_stall = dif.div_start_i && !dif.annul_i && (m_phase != M_DONE);
    total++;
    if (dif.ready_o !== e_ready) begin
      bad++;
      $display("FAIL ready t=%0t got=%0b want=%0b", $time, dif.ready_o, e_ready);
    end
    total++;
    if (dif.result_o !== e_res) begin
      bad++;
      $display("FAIL result t=%0t got=%h want=%h", $time, dif.result_o, e_res);
    end
    total++;
    if (dif.stall_req_o !== e_stall) begin
      bad++;
      $display("FAIL stall t=%0t got=%0b want=%0b", $time, dif.stall_req_o, e_stall);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Directed divide from IDLE: checks ready latency and the literal result.
  task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [63:0] want, input int want_lat);
    int lat;
    lat = -1;
    dif.div_start_i  = 1'b1;
    dif.signed_div_i = s;
    dif.opdata1_i    = a;
    dif.opdata2_i    = b;
    for (int i = 1; i <= 60 && lat < 0; i++) begin
      tick();
      if (dif.ready_o) lat = i;
    end
    check({name, "_lat"}, 64'(lat), 64'(want_lat));
    check({name, "_res"}, dif.result_o, want);
    tick();
    check({name, "_held"}, {63'd0, dif.ready_o}, 64'd1);
    dif.div_start_i = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int          seen;
    int          k;
    int          mode;
    logic [31:0] a, b;
    logic        s;

    rst              = 1'b1;
    dif.div_start_i  = 1'b0;
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd0;
    dif.opdata2_i    = 32'd0;
    dif.annul_i      = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_ready", {63'd0, dif.ready_o}, 64'd0);
    check("rst_result", dif.result_o, 64'd0);
    check("rst_stall", {63'd0, dif.stall_req_o}, 64'd0);

    check("model_divu", ref_div(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
    check("model_ovf", ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {32'd0, 32'h8000_0000});

    run_div("divu_100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 34);
    run_div("div_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 34);
    run_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, 34);
    run_div("divu_by0", 32'd1234, 32'd0, 1'b0, 64'd0, 2);
    run_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD}, 34);

    // Annul at T+10 while stepping.
    dif.div_start_i  = 1'b1;
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = 32'd5000;
    dif.opdata2_i    = 32'd3;
    repeat (10) tick();
    dif.annul_i     = 1'b1;
    dif.div_start_i = 1'b0;
    tick();
    dif.annul_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (dif.ready_o) seen++;
    end
    check("annul_no_ready", 64'(seen), 64'd0);
    run_div("divu_9_3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 34);

    // Reset at T+20 mid-divide.
    dif.div_start_i = 1'b1;
    dif.opdata1_i   = 32'd77777;
    dif.opdata2_i   = 32'd13;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ready", {63'd0, dif.ready_o}, 64'd0);
    check("midrst_result", dif.result_o, 64'd0);
    check("midrst_stall", {63'd0, dif.stall_req_o}, 64'd1);
    dif.div_start_i = 1'b0;
    repeat (2) tick();

    // Randomized traffic: normal, annulled, and start-dropped requests.
    for (int n = 0; n < 40; n++) begin
      a    = pick();
      b    = pick();
      s    = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 9);
      dif.div_start_i  = 1'b1;
      dif.signed_div_i = s;
      dif.opdata1_i    = a;
      dif.opdata2_i    = b;
      if (mode == 0) begin
        k = $urandom_range(1, 33);
        repeat (k) tick();
        dif.annul_i     = 1'b1;
        dif.div_start_i = 1'b0;
        tick();
        dif.annul_i = 1'b0;
        repeat (3) tick();
      end else if (mode == 1) begin
        k = $urandom_range(1, 30);
        repeat (k) tick();
        dif.div_start_i = 1'b0;
        dif.opdata1_i   = $urandom();
        dif.opdata2_i   = $urandom();
        repeat (36) tick();
      end else begin
        seen = 0;
        for (int i = 0; i < 60 && seen == 0; i++) begin
          tick();
          if (dif.ready_o) seen = 1;
        end
        check("rand_ready_seen", 64'(seen), 64'd1);
        repeat ($urandom_range(0, 3)) tick();
        dif.div_start_i = 1'b0;
        repeat (2) tick();
      end
    end

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
